// File: rtl/tag_pkt_arbiter_if.sv
// Stream bundle around tag_pkt_arbiter: per-tag source streams in, one merged
// packet stream out toward the tag data buffer.
interface tag_pkt_arbiter_if #(
  parameter int NUM_TAGS   = 20,
  parameter int DATA_WIDTH = 256
);
  localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

  logic [NUM_TAGS-1:0]                 s_axis_tvalid;
  logic [NUM_TAGS-1:0]                 s_axis_tready;
  logic [NUM_TAGS-1:0][DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_TAGS-1:0]                 s_axis_tlast;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic [DATA_WIDTH-1:0]               m_axis_tdata;
  logic [TW-1:0]                       m_axis_tuser;
  logic                                m_axis_tlast;

  // master: tag sources plus buffer write side; slave: the arbiter
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/tag_pkt_arbiter.sv
// Credit-gated round-robin packet arbiter: merges per-tag streams into one
// packet-atomic stream, truncating over-length packets and flagging them.
module tag_pkt_arbiter #(
  parameter  int NUM_TAGS    = 20,
  parameter  int DATA_WIDTH  = 256,
  parameter  int FIFO_DEPTH  = 1024,
  parameter  int MAX_PKT_LEN = 16,
  localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  tag_pkt_arbiter_if.slave bus,
  input  logic             credit_ret,
  output logic             busy,
  output logic [CW-1:0]    credits,
  output logic             err_len
);
  localparam int BW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t        state;
  logic [TW-1:0] grant, last_grant, pick;
  logic          pick_vld;
  logic [BW-1:0] beat_cnt;
  logic          hs, g_vld, g_last, at_max;
  int            idx;

  assign g_vld  = bus.s_axis_tvalid[grant];
  assign g_last = bus.s_axis_tlast[grant];
  assign at_max = (beat_cnt == BW'(MAX_PKT_LEN - 1));
  assign hs     = (state == PASS) && g_vld && bus.m_axis_tready;

  // Walk from farthest to nearest so the tag right after last_grant wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_TAGS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_TAGS;
      if (bus.s_axis_tvalid[idx]) begin
        pick     = TW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign bus.m_axis_tvalid = (state == PASS) && g_vld;
  assign bus.m_axis_tdata  = bus.s_axis_tdata[grant];
  assign bus.m_axis_tuser  = grant;
  assign bus.m_axis_tlast  = (state == PASS) && (g_last || at_max);
  assign busy              = (state != IDLE);

  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_rdy
    assign bus.s_axis_tready[i] = (grant == TW'(i)) &&
      (((state == PASS) && bus.m_axis_tready) || (state == DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= TW'(NUM_TAGS - 1);
      beat_cnt   <= '0;
      err_len    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Only grant when a worst-case packet fits downstream.
          if (enable && (credits >= CW'(MAX_PKT_LEN)) && pick_vld) begin
            grant      <= pick;
            last_grant <= pick;
            beat_cnt   <= '0;
            state      <= PASS;
          end
        end
        PASS: begin
          if (hs) begin
            if (g_last) begin
              state <= IDLE;
            end else if (at_max) begin
              err_len <= 1'b1;
              state   <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (g_vld && g_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CW'(FIFO_DEPTH);
    end else if (hs && !credit_ret) begin
      credits <= credits - CW'(1);
    end else if (!hs && credit_ret && (credits != CW'(FIFO_DEPTH))) begin
      credits <= credits + CW'(1);
    end
  end
endmodule

// File: tb/tb_tag_pkt_arbiter.sv
// Scoreboard bench for tag_pkt_arbiter: per-tag expected beat queues, a
// credit count model and grant-order logs against directed and random traffic.
module tb_tag_pkt_arbiter;
  localparam int NT = 20;
  localparam int DW = 256;
  localparam int FD = 1024;
  localparam int ML = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic credit_ret;
  logic busy, err_len;
  logic [$clog2(FD+1)-1:0] credits;

  always #5 clk = ~clk;

  tag_pkt_arbiter_if #(.NUM_TAGS(NT), .DATA_WIDTH(DW)) bus();

  tag_pkt_arbiter #(.NUM_TAGS(NT), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_PKT_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .credit_ret(credit_ret), .busy(busy), .credits(credits), .err_len(err_len)
  );

  int    checks = 0, errors = 0, cyc = 0;
  beat_t src_q[NT][$];
  beat_t exp_q[NT][$];
  int    grant_log[$], start_log[$], end_log[$];
  int    cred_m = FD;
  bit    exp_err = 1'b0;
  bit    gap_mode = 1'b0, rand_bp = 1'b0, rand_cr = 1'b0, tready_cfg = 1'b1;
  int    cr_req = 0, cr_done = 0;
  bit    in_pkt = 1'b0;
  int    pkt_beats = 0, cur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Source beats go to the driver; the first ML beats (tlast forced on the
  // ML-th for long packets) are what the merged stream must carry.
  task automatic push_pkt(input int tag, input int len);
    int    n;
    beat_t b;
    n = (len > ML) ? ML : len;
    for (int i = 0; i < len; i++) begin
      b.data = rand_data();
      b.last = (i == len - 1);
      src_q[tag].push_back(b);
      if (i < n) begin
        b.last = (i == n - 1);
        exp_q[tag].push_back(b);
      end
    end
    if (len > ML) exp_err = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit all_empty();
    for (int t = 0; t < NT; t++)
      if (src_q[t].size() != 0 || exp_q[t].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (!(all_empty() && !busy) && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    start_log.delete();
    end_log.delete();
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_count"}, grant_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      chk({name, "_tag"}, grant_log[i], exp[i]);
  endtask

  // Driver: handshakes sampled at negedge, new source values applied after posedge.
  initial begin : drv
    logic [NT-1:0] acc;
    bit            pres[NT];
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.m_axis_tready = 1'b1;
    credit_ret        = 1'b0;
    for (int t = 0; t < NT; t++) pres[t] = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      #1;
      for (int t = 0; t < NT; t++) begin
        if (acc[t] && src_q[t].size() != 0) begin
          void'(src_q[t].pop_front());
          pres[t] = 1'b0;
        end
        if (src_q[t].size() == 0) pres[t] = 1'b0;
        else if (!pres[t] && (!gap_mode || $urandom_range(0, 3) != 0)) pres[t] = 1'b1;
        bus.s_axis_tvalid[t] = pres[t];
        bus.s_axis_tdata[t]  = pres[t] ? src_q[t][0].data : '0;
        bus.s_axis_tlast[t]  = pres[t] ? src_q[t][0].last : 1'b0;
      end
      bus.m_axis_tready = rand_bp ? 1'($urandom_range(0, 1)) : tready_cfg;
      if (rand_cr) begin
        credit_ret = ($urandom_range(0, 3) == 0);
      end else if (cr_done < cr_req) begin
        credit_ret = 1'b1;
        cr_done++;
      end else begin
        credit_ret = 1'b0;
      end
    end
  end

  // Monitor: pops the expected beat for the tag named by tuser, tracks credits.
  initial begin : mon
    beat_t e;
    int    g;
    bit    hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cred_m    = FD;
        in_pkt    = 1'b0;
        pkt_beats = 0;
      end else begin
        chk("tready_onehot0", $onehot0(bus.s_axis_tready), 1);
        chk("credits", credits, cred_m);
        hs = bus.m_axis_tvalid && bus.m_axis_tready;
        if (hs) begin
          g = int'(bus.m_axis_tuser);
          if (!in_pkt) begin
            grant_log.push_back(g);
            start_log.push_back(cyc);
            cur       = g;
            pkt_beats = 0;
          end else begin
            chk("tuser_stable", g, cur);
          end
          pkt_beats++;
          checks++;
          if (g >= NT || exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected beat on tag %0d, none required", g);
          end else begin
            e = exp_q[g].pop_front();
            if (bus.m_axis_tdata !== e.data || bus.m_axis_tlast !== e.last) begin
              errors++;
              $display("FAIL beat tag %0d: data %h last %0b, required %h last %0b",
                       g, bus.m_axis_tdata, bus.m_axis_tlast, e.data, e.last);
            end
          end
          in_pkt = !bus.m_axis_tlast;
          if (bus.m_axis_tlast) end_log.push_back(cyc);
        end
        cred_m = cred_m - int'(hs) + int'(credit_ret);
        if (cred_m > FD) cred_m = FD;
      end
    end
  end

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e[$];
    int c0, k;
    tick(3);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_m_tlast", bus.m_axis_tlast, 0);
    chk("rst_m_tuser", bus.m_axis_tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credits", credits, FD);
    chk("rst_err_len", err_len, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(2);
    chk("post_rst_busy", busy, 0);

    // Three tags offer simultaneously: served 0,3,7 with one gap cycle each.
    clear_logs();
    push_pkt(0, 4); push_pkt(3, 4); push_pkt(7, 4);
    wait_idle(200, "three_tags");
    e = '{0, 3, 7};
    chk_log("three_tags", e);
    for (int i = 0; i < end_log.size() && i < start_log.size(); i++)
      chk("pkt_len_cycles", end_log[i] - start_log[i], 3);
    for (int i = 1; i < start_log.size(); i++)
      chk("pkt_spacing", start_log[i] - start_log[i-1], 5);
    chk("credits_after_12", credits, FD - 12);

    // Continuous one-beat requesters alternate, including wrap past tag 19.
    clear_logs();
    for (int i = 0; i < 4; i++) begin push_pkt(2, 1); push_pkt(5, 1); end
    wait_idle(200, "rr_2_5");
    e = '{2, 5, 2, 5, 2, 5, 2, 5};
    chk_log("rr_2_5", e);
    for (int i = 1; i < start_log.size(); i++)
      chk("rr_gap", start_log[i] - start_log[i-1], 2);
    clear_logs();
    for (int i = 0; i < 2; i++) begin push_pkt(19, 1); push_pkt(0, 1); end
    wait_idle(200, "rr_wrap");
    e = '{19, 0, 19, 0};
    chk_log("rr_wrap", e);

    // Truncation; enable dropped mid-packet must not disturb it.
    chk("err_len_before", err_len, 0);
    c0 = int'(credits);
    clear_logs();
    push_pkt(4, 20);
    tick(4);
    enable = 1'b0;
    wait_idle(200, "trunc");
    enable = 1'b1;
    chk("err_len_after", err_len, 1);
    chk("trunc_credits", credits, c0 - ML);
    e = '{4};
    chk_log("trunc", e);
    if (end_log.size() > 0 && start_log.size() > 0)
      chk("trunc_beats", end_log[0] - start_log[0], ML - 1);

    // No grant while enable is low.
    enable = 1'b0;
    clear_logs();
    push_pkt(9, 1);
    tick(6);
    chk("disabled_busy", busy, 0);
    chk("disabled_tready", bus.s_axis_tready, 0);
    enable = 1'b1;
    wait_idle(50, "enable");
    e = '{9};
    chk_log("enable", e);

    // Asynchronous reset in the middle of a packet on tag 5.
    clear_logs();
    push_pkt(5, 6);
    k = 0;
    while (!(in_pkt && pkt_beats >= 2) && k < 50) begin tick(1); k++; end
    chk("reach_beat2", k < 50, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_s_tready", bus.s_axis_tready, 0);
    chk("arst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("arst_m_tlast", bus.m_axis_tlast, 0);
    chk("arst_m_tuser", bus.m_axis_tuser, 0);
    chk("arst_busy", busy, 0);
    chk("arst_credits", credits, FD);
    chk("arst_err_len", err_len, 0);
    for (int t = 0; t < NT; t++) begin src_q[t].delete(); exp_q[t].delete(); end
    exp_err = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    push_pkt(0, 1); push_pkt(6, 1);
    wait_idle(50, "post_arst");
    e = '{0, 6};
    chk_log("post_arst", e);
    chk("post_arst_credits", credits, FD - 2);

    // Random traffic, source gaps, backpressure and credit returns.
    gap_mode = 1'b1; rand_bp = 1'b1; rand_cr = 1'b1;
    clear_logs();
    for (int i = 0; i < 60; i++) push_pkt($urandom_range(0, NT-1), $urandom_range(1, 20));
    wait_idle(20000, "random");
    gap_mode = 1'b0; rand_bp = 1'b0; rand_cr = 1'b0;
    tick(2);
    chk("random_err_len", err_len, exp_err);

    // Saturate credits, then exhaust them with 16-beat packets and stall.
    cr_req = cr_req + 1100;
    tick(1110);
    chk("credits_saturated", credits, FD);
    clear_logs();
    for (int i = 0; i < FD/ML + 1; i++) push_pkt(1, ML);
    k = 0;
    while (!(src_q[1].size() == ML && !busy) && k < 3000) begin tick(1); k++; end
    chk("stall_reached", k < 3000, 1);
    tick(5);
    chk("stall_busy", busy, 0);
    chk("stall_credits", credits, 0);
    chk("stall_tready", bus.s_axis_tready, 0);
    chk("stall_pkts", grant_log.size(), FD/ML);
    cr_req = cr_req + ML;
    k = 0;
    while (credits != ML && k < 40) begin tick(1); k++; end
    chk("credit_return", credits, ML);
    chk("no_early_grant", busy, 0);
    tick(1);
    chk("grant_after_credit", busy, 1);
    wait_idle(100, "stall_release");
    chk("final_credits", credits, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
